// File: rtl/rx_pkg.sv
// Shared definitions for the 802.16 receive-side de-randomizer: PRBS seed,
// FSM state type and the byte-wide PRBS step.
package rx_pkg;

    localparam logic [14:0] PRBS_SEED_802_16 = 15'b100101010000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rx_state_e;

    // Eight serial steps of 1 + x^14 + x^15, first step lands in mask[7].
    function automatic logic [22:0] prbs8(input logic [14:0] s);
        logic [14:0] st;
        logic [7:0]  m;
        logic        p;
        st = s;
        m  = '0;
        for (int i = 7; i >= 0; i--) begin
            p    = st[14] ^ st[13];
            m[i] = p;
            st   = {st[13:0], p};
        end
        return {st, m};
    endfunction

endpackage

// File: rtl/rx_byte_fifo2.sv
// Two-entry byte FIFO; a read and a write in the same cycle keep the count,
// so a full buffer can accept while it is being popped.
module rx_byte_fifo2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr,
    input  logic [7:0] i_wdata,
    input  logic       i_rd,
    output logic [7:0] o_rdata,
    output logic       o_full,
    output logic       o_empty
);

    logic [7:0] r_mem [0:1];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_rd;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_rd    = i_rd & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= 8'h00;
            r_mem[1] <= 8'h00;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_wr) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_rd) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_wr, w_rd})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rx_derandomizer.sv
// 802.16 byte de-randomizer: burst FSM plus PRBS register feeding a 2-entry
// output buffer, reseeded at every burst start.
module rx_derandomizer
    import rx_pkg::*;
(
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] DAT_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic       WE_I,
    output logic       ACK_O,
    output logic [7:0] DAT_O,
    output logic       CYC_O,
    output logic       STB_O,
    output logic       WE_O,
    input  logic       ACK_I,
    output logic [1:0] o_dbg_state
);

    rx_state_e   r_state;
    logic [14:0] r_prbs;

    logic [22:0] w_prbs8;
    logic [7:0]  w_mask;
    logic [14:0] w_prbs_next;
    logic        w_full;
    logic        w_empty;
    logic        w_rd;
    logic        w_accept;

    assign w_prbs8     = prbs8(r_prbs);
    assign w_mask      = w_prbs8[7:0];
    assign w_prbs_next = w_prbs8[22:8];

    // A pop this cycle frees a slot, so a full buffer may still accept.
    assign w_rd     = ACK_I & ~w_empty;
    assign w_accept = (r_state == RUN) & CYC_I & STB_I & WE_I & (~w_full | w_rd);

    assign ACK_O       = w_accept;
    assign STB_O       = ~w_empty;
    assign WE_O        = ~w_empty;
    assign CYC_O       = (r_state != IDLE);
    assign o_dbg_state = r_state;

    rx_byte_fifo2 u_fifo (
        .i_clk   (CLK_I),
        .i_rst_n (RST_I),
        .i_wr    (w_accept),
        .i_wdata (DAT_I ^ w_mask),
        .i_rd    (w_rd),
        .o_rdata (DAT_O),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A new burst is held in IDLE until the previous burst has fully drained.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state <= IDLE;
            r_prbs  <= PRBS_SEED_802_16;
        end else begin
            case (r_state)
                IDLE: begin
                    if (CYC_I && w_empty) begin
                        r_prbs  <= PRBS_SEED_802_16;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_prbs <= w_prbs_next;
                    end
                    if (!CYC_I) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_derandomizer.sv
// Self-checking bench for rx_derandomizer: burst driver, PRBS sequence model
// and an output scoreboard.
module tb_rx_derandomizer;

    logic       CLK_I = 1'b0;
    logic       RST_I;
    logic [7:0] DAT_I;
    logic       CYC_I;
    logic       STB_I;
    logic       WE_I;
    logic       ACK_I;
    logic       ACK_O;
    logic [7:0] DAT_O;
    logic       CYC_O;
    logic       STB_O;
    logic       WE_O;
    logic [1:0] dbg_state;

    int checks = 0;
    int passed = 0;

    logic [7:0] mask_tab [0:127];
    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] out_log[$];

    logic       ack_force_low = 1'b0;
    logic       ack_random    = 1'b0;
    logic       hold_prev     = 1'b0;
    logic [7:0] dat_prev      = 8'h00;

    rx_derandomizer dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .DAT_I       (DAT_I),
        .CYC_I       (CYC_I),
        .STB_I       (STB_I),
        .WE_I        (WE_I),
        .ACK_O       (ACK_O),
        .DAT_O       (DAT_O),
        .CYC_O       (CYC_O),
        .STB_O       (STB_O),
        .WE_O        (WE_O),
        .ACK_I       (ACK_I),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / downstream acknowledge ----------------
    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) begin
        #1;
        if (ack_force_low)   ACK_I = 1'b0;
        else if (ack_random) ACK_I = 1'($urandom_range(0, 1));
        else                 ACK_I = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // ---------------- reference model: PRBS as a bit sequence ----------------
    // a[k+15] = a[k] ^ a[k+1]; the seed supplies a[0..14] with s[14] first.
    function automatic void build_masks();
        logic [14:0] seed;
        logic        a [0:1100];
        seed = 15'b100101010000000;
        for (int k = 0; k < 15; k++) a[k] = seed[14-k];
        for (int k = 15; k <= 1100; k++) a[k] = a[k-15] ^ a[k-14];
        for (int j = 0; j < 128; j++)
            for (int b = 0; b < 8; b++)
                mask_tab[j][7-b] = a[15 + 8*j + b];
    endfunction

    // ---------------- scoreboard / output monitor ----------------
    always @(negedge CLK_I) begin
        logic [7:0] e;
        if (RST_I !== 1'b1) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (STB_O !== 1'b1 || DAT_O !== dat_prev)
                    $display("FAIL hold_stable: STB_O=%b DAT_O=%h required STB_O=1 DAT_O=%h", STB_O, DAT_O, dat_prev);
                else passed++;
            end
            if (STB_O === 1'b1) begin
                checks++;
                if (WE_O !== 1'b1) $display("FAIL we_eq_stb: WE_O=%b required 1", WE_O);
                else passed++;
            end
            if (STB_O === 1'b1 && ACK_I === 1'b1) begin
                out_log.push_back(DAT_O);
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL out_extra: DAT_O=%h with no byte expected", DAT_O);
                end else begin
                    e = exp_q.pop_front();
                    if (DAT_O !== e) $display("FAIL out_data: DAT_O=%h required %h", DAT_O, e);
                    else passed++;
                end
            end
            hold_prev = (STB_O === 1'b1) && (ACK_I === 1'b0);
            dat_prev  = DAT_O;
        end
    end

    // ---------------- driver ----------------
    // ACK_I goes low from cycle on_c+1 and high again from cycle off_c+1.
    task automatic drive_burst(input int n, input int on_c, input int off_c,
                               input int we_from, input int we_len,
                               output int cycles, output int first_ack,
                               output int low_acks, output logic [63:0] ack_map);
        int idx = 0;
        int pos = 0;
        int c   = 0;
        first_ack = -1;
        low_acks  = 0;
        ack_map   = '0;
        @(posedge CLK_I); #1;
        CYC_I = 1'b1;
        while (idx < n && c < 400) begin
            STB_I = 1'b1;
            DAT_I = in_q[idx];
            WE_I  = !(c >= we_from && c < we_from + we_len);
            @(negedge CLK_I);
            if (ACK_O === 1'b1) begin
                if (first_ack < 0) first_ack = c;
                if (ACK_I === 1'b0) low_acks++;
                if (c < 64) ack_map[c] = 1'b1;
                exp_q.push_back(DAT_I ^ mask_tab[pos]);
                pos++;
                idx++;
            end
            if (WE_I === 1'b0) begin
                checks++;
                if (ACK_O !== 1'b0) $display("FAIL we_low_ack: ACK_O=%b required 0 at cycle %0d", ACK_O, c);
                else passed++;
            end
            if (c == on_c)  ack_force_low = 1'b1;
            if (c == off_c) ack_force_low = 1'b0;
            c++;
            @(posedge CLK_I); #1;
        end
        if (idx < n) begin
            checks++;
            $display("FAIL burst_timeout: accepted %0d required %0d", idx, n);
        end
        CYC_I  = 1'b0;
        STB_I  = 1'b0;
        WE_I   = 1'b0;
        cycles = c;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK_I);
            if (CYC_O === 1'b0 && exp_q.size() == 0) break;
        end
        checks++;
        if (CYC_O !== 1'b0 || exp_q.size() != 0)
            $display("FAIL drain: CYC_O=%b pending=%0d required CYC_O=0 pending=0", CYC_O, exp_q.size());
        else passed++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = 8'h00; ACK_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #2;
        checks += 5;
        if (ACK_O !== 1'b0) $display("FAIL rst_ack: ACK_O=%b required 0", ACK_O); else passed++;
        if (STB_O !== 1'b0) $display("FAIL rst_stb: STB_O=%b required 0", STB_O); else passed++;
        if (WE_O  !== 1'b0) $display("FAIL rst_we: WE_O=%b required 0", WE_O); else passed++;
        if (CYC_O !== 1'b0) $display("FAIL rst_cyc: CYC_O=%b required 0", CYC_O); else passed++;
        if (DAT_O !== 8'h00) $display("FAIL rst_dat: DAT_O=%h required 00", DAT_O); else passed++;
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
    endtask

    task automatic test_known_vector();
        int cy, fa, la;
        logic [63:0] am;
        out_log.delete();
        in_q = '{8'h00, 8'h00};
        drive_burst(2, -1, -1, -1, 0, cy, fa, la, am);
        checks += 2;
        if (cy != 3) $display("FAIL kv_cycles: took %0d cycles required 3", cy); else passed++;
        if (am[2:0] != 3'b110) $display("FAIL kv_ack_map: ack cycles %b required 110", am[2:0]); else passed++;
        @(negedge CLK_I);
        checks++;
        if (CYC_O !== 1'b1) $display("FAIL kv_cyc1: CYC_O=%b required 1", CYC_O); else passed++;
        @(negedge CLK_I);
        checks++;
        if (CYC_O !== 1'b1) $display("FAIL kv_cyc2: CYC_O=%b required 1", CYC_O); else passed++;
        @(negedge CLK_I);
        checks++;
        if (CYC_O !== 1'b0) $display("FAIL kv_cyc_fall: CYC_O=%b required 0", CYC_O); else passed++;
        wait_drain();
        checks += 3;
        if (out_log.size() != 2) $display("FAIL kv_count: %0d bytes required 2", out_log.size()); else passed++;
        if (out_log.size() > 0 && out_log[0] !== 8'hBF) $display("FAIL kv_byte0: %h required bf", out_log[0]); else passed++;
        if (out_log.size() > 1 && out_log[1] !== 8'h03) $display("FAIL kv_byte1: %h required 03", out_log[1]); else passed++;
    endtask

    task automatic test_round_trip();
        int cy, fa, la;
        logic [63:0] am;
        out_log.delete();
        in_q = '{8'hBF, 8'h03};
        drive_burst(2, -1, -1, -1, 0, cy, fa, la, am);
        wait_drain();
        checks += 2;
        if (out_log.size() != 2 || out_log[0] !== 8'h00) $display("FAIL rt_byte0: got %0d bytes, first %h required 00", out_log.size(), out_log[0]); else passed++;
        if (out_log.size() != 2 || out_log[1] !== 8'h00) $display("FAIL rt_byte1: got %0d bytes, second %h required 00", out_log.size(), out_log[1]); else passed++;
    endtask

    task automatic test_random_burst();
        int cy, fa, la;
        logic [63:0] am;
        out_log.delete();
        in_q.delete();
        for (int i = 0; i < 100; i++) in_q.push_back(8'($urandom_range(0, 255)));
        ack_random = 1'b1;
        drive_burst(100, -1, -1, -1, 0, cy, fa, la, am);
        ack_random = 1'b0;
        wait_drain();
        checks++;
        if (out_log.size() != 100) $display("FAIL rand_count: %0d bytes required 100", out_log.size()); else passed++;
    endtask

    task automatic test_back_pressure();
        int cy, fa, la;
        logic [63:0] am;
        out_log.delete();
        in_q.delete();
        for (int i = 0; i < 10; i++) in_q.push_back(8'($urandom_range(0, 255)));
        drive_burst(10, 0, 5, -1, 0, cy, fa, la, am);
        wait_drain();
        checks += 4;
        if (la != 2) $display("FAIL bp_stall_accepts: %0d accepts while stalled required 2", la); else passed++;
        if (am[5:3] != 3'b000) $display("FAIL bp_ack_drop: ack cycles 3..5 %b required 000", am[5:3]); else passed++;
        if (am[6] != 1'b1) $display("FAIL bp_ack_on_pop: ack at pop cycle %b required 1", am[6]); else passed++;
        if (out_log.size() != 10) $display("FAIL bp_count: %0d bytes required 10", out_log.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        int cy, fa, la;
        logic [63:0] am;
        out_log.delete();
        @(negedge CLK_I);
        ack_force_low = 1'b1;
        in_q = '{8'h00, 8'h00};
        drive_burst(2, -1, -1, -1, 0, cy, fa, la, am);
        drive_burst(2, -1, 3, -1, 0, cy, fa, la, am);
        wait_drain();
        checks += 3;
        if (fa != 8) $display("FAIL b2b_first_ack: first ack at cycle %0d required 8", fa); else passed++;
        if (out_log.size() != 4) $display("FAIL b2b_count: %0d bytes required 4", out_log.size()); else passed++;
        if (out_log.size() == 4 && (out_log[2] !== 8'hBF || out_log[3] !== 8'h03))
            $display("FAIL b2b_reseed: second burst %h %h required bf 03", out_log[2], out_log[3]);
        else if (out_log.size() == 4) passed++;
    endtask

    task automatic test_we_gap();
        int cy, fa, la;
        logic [63:0] am;
        out_log.delete();
        in_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_burst(6, -1, -1, 2, 3, cy, fa, la, am);
        wait_drain();
        checks += 2;
        if (cy != 10) $display("FAIL we_cycles: took %0d cycles required 10", cy); else passed++;
        if (out_log.size() != 6) $display("FAIL we_count: %0d bytes required 6", out_log.size()); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        int cy, fa, la;
        logic [63:0] am;
        @(negedge CLK_I);
        ack_force_low = 1'b1;
        in_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        drive_burst(2, -1, -1, -1, 0, cy, fa, la, am);
        #2;
        checks++;
        if (STB_O !== 1'b1) $display("FAIL rm_pre_stb: STB_O=%b required 1", STB_O); else passed++;
        RST_I = 1'b0;
        #1;
        checks += 5;
        if (STB_O !== 1'b0) $display("FAIL rm_stb: STB_O=%b required 0", STB_O); else passed++;
        if (WE_O  !== 1'b0) $display("FAIL rm_we: WE_O=%b required 0", WE_O); else passed++;
        if (CYC_O !== 1'b0) $display("FAIL rm_cyc: CYC_O=%b required 0", CYC_O); else passed++;
        if (ACK_O !== 1'b0) $display("FAIL rm_ack: ACK_O=%b required 0", ACK_O); else passed++;
        if (DAT_O !== 8'h00) $display("FAIL rm_dat: DAT_O=%h required 00", DAT_O); else passed++;
        @(negedge CLK_I);
        ack_force_low = 1'b0;
        exp_q.delete();
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        out_log.delete();
        in_q = '{8'h00, 8'h00};
        drive_burst(2, -1, -1, -1, 0, cy, fa, la, am);
        wait_drain();
        checks++;
        if (out_log.size() == 0 || out_log[0] !== 8'hBF)
            $display("FAIL rm_reseed: %0d bytes, first %h required bf", out_log.size(), out_log.size() > 0 ? out_log[0] : 8'h00);
        else passed++;
    endtask

    initial begin
        build_masks();
        test_reset();
        test_known_vector();
        test_round_trip();
        test_random_burst();
        test_back_pressure();
        test_back_to_back();
        test_we_gap();
        test_reset_mid_burst();
        repeat (3) @(posedge CLK_I);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
